uart_tx_frame: RTL and testbench
================================

Name: uart_tx_frame

Overview:
Parametrised UART transmitter with configurable data width, baud divisor, parity mode and stop-bit count.
- Accepts one word per valid/ready handshake and serialises it LSB-first on a single line.
- Frame: start bit, data, optional parity, stop bit(s); every bit lasts CLKS_PER_BIT clocks.
- Sits between a byte-producing controller (or FIFO) and the pad.
- Next generation of the fixed-width transmitter: adds a baud divisor, parity, multiple stop bits, handshake and a done pulse.

Parameters:
DATA_W, 8, data bits per frame; legal 1..16.
CLKS_PER_BIT, 4, clock cycles per serial bit; legal >= 1.
PARITY_MODE, 0, 0 = none, 1 = even, 2 = odd; other values are an elaboration error.
STOP_BITS, 1, stop bits per frame; legal 1 or 2, other values are an elaboration error.

Ports:
clk  in  1  clock, all logic on rising edge.
rst  in  1  reset, asynchronous, active-low; asserting it immediately forces the reset state.
tx_valid  in  1  producer has a word on tx_data.
tx_data  in  DATA_W  word to send, sampled only at acceptance.
tx_ready  out  1  block can accept a word; combinational, equal to (state == IDLE).
tx  out  1  serial line, registered, idle high.
tx_busy  out  1  registered; high from the cycle after acceptance through the last stop-bit cycle.
tx_done  out  1  registered one-cycle pulse in the last clock of the final stop bit.

Behaviour:
- Reset values: tx = 1, tx_busy = 0, tx_done = 0, state = IDLE (so tx_ready = 1), baud counter = 0, bit counter = 0, shift register = 0.
- Reset mid-frame: the frame is abandoned at once and tx returns high asynchronously. No tx_done is produced. After release the block restarts in IDLE.
- Acceptance: at a rising edge with state IDLE and tx_valid = 1.
  - tx_data is latched into the shift register.
  - Parity is computed from the latched data: even = XOR of the bits, odd = its inverse.
  - Next cycle: state = START, tx = 0, tx_busy = 1.
- tx_valid while not IDLE is ignored; no queuing.
- tx_data may change freely after acceptance.
- Bit timing: the baud counter counts 0..CLKS_PER_BIT-1. On reaching CLKS_PER_BIT-1 it wraps to 0 and a bit tick advances the FSM. Each serial bit is therefore held exactly CLKS_PER_BIT cycles.
- FSM transitions on bit tick:
  - START -> DATA.
  - DATA: shift right, tx = current LSB. The bit counter runs 0..DATA_W-1. On the last data bit go to PARITY if PARITY_MODE != 0, else STOP.
  - PARITY: tx = parity bit, then -> STOP.
  - STOP: tx = 1. The stop counter runs 0..STOP_BITS-1. On the last tick -> IDLE with tx_done = 1 in that final cycle.
- Next cycle after the frame: tx_busy = 0 and tx_ready = 1.
- Frame length: (1 + DATA_W + (PARITY_MODE != 0) + STOP_BITS) * CLKS_PER_BIT cycles.
- Frame spacing: minimum one idle cycle between frames (the IDLE acceptance cycle). Maximum throughput is one frame per frame length + 1 cycles.
- CLKS_PER_BIT = 1: the baud counter is a constant 0 and a tick fires every cycle; the same rules apply.
- Counter widths:
  - baud counter: $clog2(CLKS_PER_BIT) bits, minimum 1.
  - bit counter: $clog2(DATA_W) bits, minimum 1.
  - No counter may overflow before its wrap compare.
- tx is driven only from registers; there is no combinational path from inputs to tx.

Decomposition:
- Package uart_pkg holds:
  - state enum (IDLE, START, DATA, PARITY, STOP);
  - parity mode constants PAR_NONE = 0, PAR_EVEN = 1, PAR_ODD = 2;
  - function frame_bits(DATA_W, PARITY_MODE, STOP_BITS) used by the bench.
- Sub-module uart_baud_tick:
  - parameter CLKS_PER_BIT; inputs clk, rst, en; output tick;
  - counter cleared whenever en = 0;
  - en is high whenever the FSM is not IDLE.

Test Plan:
1. DATA_W=8, CLKS_PER_BIT=4, even parity, 1 stop; send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,0(parity),1, each held 4 cycles; tx_busy high 44 cycles; tx_done once in cycle 44.
2. Same configuration, odd parity, 0x00 -> parity bit 1; 2 stop bits -> 12 bits, 48 busy cycles.
3. tx_valid held high continuously with 0x3C then 0xC3 -> second word accepted in the IDLE cycle after tx_done; exactly 1 idle-high cycle between frames; tx_valid during a frame never changes the in-flight frame.
4. Assert rst low in the middle of data bit 3 -> tx = 1 immediately, tx_busy = 0, no tx_done; after release, a new 0x55 frame is sent correctly.
5. CLKS_PER_BIT=1, DATA_W=5, no parity, 1 stop; send 5'b10011 -> tx = 0,1,1,0,0,1,1 on consecutive cycles; frame 7 cycles.
6. Protocol checks, all configurations:
   - tx == 1 whenever tx_busy == 0;
   - tx_ready == !tx_busy, except in the acceptance cycle;
   - tx_done occurs exactly once per accepted word.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the framed UART transmitter.
package uart_pkg;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   // Serial bits in one frame: start + data + optional parity + stop bits.
   function automatic int frame_bits(input int data_w, input int parity_mode, input int stop_bits);
      return 1 + data_w + ((parity_mode != PAR_NONE) ? 1 : 0) + stop_bits;
   endfunction

endpackage

// File: rtl/uart_tx_frame_baud_tick.sv
// Baud divider: tick marks the last clock of every serial bit while enabled.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic tick,
   output logic tick_next
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         cnt <= '0;
      else if (!en || cnt == LAST)
         cnt <= '0;
      else
         cnt <= cnt + CW'(1);
   end

   assign tick = en && (cnt == LAST);

   // tick_next: the following clock will carry a tick, assuming en stays high.
   generate
      if (CLKS_PER_BIT == 1) begin : g_single
         assign tick_next = 1'b1;
      end else begin : g_multi
         assign tick_next = en && (cnt == CW'(CLKS_PER_BIT - 2));
      end
   endgenerate

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
module uart_tx_frame
   import uart_pkg::*;
#(
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 4,
   parameter int PARITY_MODE  = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_ready,
   output logic              tx,
   output logic              tx_busy,
   output logic              tx_done
);

   generate
      if (DATA_W < 1 || DATA_W > 16) begin : g_bad_data_w
         $error("uart_tx_frame: DATA_W must be in 1..16");
      end
      if (CLKS_PER_BIT < 1) begin : g_bad_clks
         $error("uart_tx_frame: CLKS_PER_BIT must be >= 1");
      end
      if (PARITY_MODE != PAR_NONE && PARITY_MODE != PAR_EVEN && PARITY_MODE != PAR_ODD) begin : g_bad_parity
         $error("uart_tx_frame: PARITY_MODE must be 0, 1 or 2");
      end
      if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
         $error("uart_tx_frame: STOP_BITS must be 1 or 2");
      end
   endgenerate

   localparam int             BW        = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [BW-1:0]  BIT_LAST  = BW'(DATA_W - 1);
   localparam logic           STOP_LAST = 1'(STOP_BITS - 1);

   state_t            state, state_n;
   logic [DATA_W-1:0] sh, sh_n;
   logic [BW-1:0]     bit_cnt, bit_cnt_n;
   logic              stop_cnt, stop_cnt_n;
   logic              par, par_n;
   logic              tx_n, busy_n, done_n;
   logic              tick, tick_next;

   uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
      .clk      (clk),
      .rst      (rst),
      .en       (state != IDLE),
      .tick     (tick),
      .tick_next(tick_next)
   );

   assign tx_ready = (state == IDLE);

   always_comb begin
      state_n    = state;
      sh_n       = sh;
      bit_cnt_n  = bit_cnt;
      stop_cnt_n = stop_cnt;
      par_n      = par;
      tx_n       = tx;
      unique case (state)
         IDLE: begin
            tx_n = 1'b1;
            if (tx_valid) begin
               state_n = START;
               sh_n    = tx_data;
               par_n   = (PARITY_MODE == PAR_ODD) ? ~^tx_data : ^tx_data;
               tx_n    = 1'b0;
            end
         end
         START: if (tick) begin
            state_n   = DATA;
            bit_cnt_n = '0;
            tx_n      = sh[0];
            sh_n      = sh >> 1;
         end
         DATA: if (tick) begin
            if (bit_cnt == BIT_LAST) begin
               if (PARITY_MODE != PAR_NONE) begin
                  state_n = PARITY;
                  tx_n    = par;
               end else begin
                  state_n    = STOP;
                  stop_cnt_n = 1'b0;
                  tx_n       = 1'b1;
               end
            end else begin
               bit_cnt_n = bit_cnt + BW'(1);
               tx_n      = sh[0];
               sh_n      = sh >> 1;
            end
         end
         PARITY: if (tick) begin
            state_n    = STOP;
            stop_cnt_n = 1'b0;
            tx_n       = 1'b1;
         end
         STOP: if (tick) begin
            if (stop_cnt == STOP_LAST)
               state_n = IDLE;
            else
               stop_cnt_n = stop_cnt + 1'b1;
         end
         default: state_n = IDLE;
      endcase
      busy_n = (state_n != IDLE);
      // Look one clock ahead so the registered done lands in the final stop-bit clock.
      done_n = (state_n == STOP) && (stop_cnt_n == STOP_LAST) && tick_next;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         sh       <= '0;
         bit_cnt  <= '0;
         stop_cnt <= 1'b0;
         par      <= 1'b0;
         tx       <= 1'b1;
         tx_busy  <= 1'b0;
         tx_done  <= 1'b0;
      end else begin
         state    <= state_n;
         sh       <= sh_n;
         bit_cnt  <= bit_cnt_n;
         stop_cnt <= stop_cnt_n;
         par      <= par_n;
         tx       <= tx_n;
         tx_busy  <= busy_n;
         tx_done  <= done_n;
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame across three parameter sets.
`timescale 1ns/1ps
module tb_uart_tx_frame;
   import uart_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst;
   logic       va, vb, vc;
   logic [7:0] da, db;
   logic [4:0] dc;
   logic       rdy_a, tx_a, busy_a, done_a;
   logic       rdy_b, tx_b, busy_b, done_b;
   logic       rdy_c, tx_c, busy_c, done_c;

   int errors = 0;
   int checks = 0;
   int acc_a = 0, acc_b = 0, acc_c = 0;
   int dn_a = 0, dn_b = 0, dn_c = 0;

   // Parameter sets of the three instances, indexed by selector 0/1/2.
   int cpb_c [3] = '{4, 4, 1};
   int dw_c  [3] = '{8, 8, 5};
   int pm_c  [3] = '{PAR_EVEN, PAR_ODD, PAR_NONE};
   int sb_c  [3] = '{1, 2, 1};

   uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(PAR_EVEN), .STOP_BITS(1)) dut_a (
      .clk(clk), .rst(rst), .tx_valid(va), .tx_data(da),
      .tx_ready(rdy_a), .tx(tx_a), .tx_busy(busy_a), .tx_done(done_a));

   uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_MODE(PAR_ODD), .STOP_BITS(2)) dut_b (
      .clk(clk), .rst(rst), .tx_valid(vb), .tx_data(db),
      .tx_ready(rdy_b), .tx(tx_b), .tx_busy(busy_b), .tx_done(done_b));

   uart_tx_frame #(.DATA_W(5), .CLKS_PER_BIT(1), .PARITY_MODE(PAR_NONE), .STOP_BITS(1)) dut_c (
      .clk(clk), .rst(rst), .tx_valid(vc), .tx_data(dc),
      .tx_ready(rdy_c), .tx(tx_c), .tx_busy(busy_c), .tx_done(done_c));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic tx_of(input int s);
      return (s == 0) ? tx_a : (s == 1) ? tx_b : tx_c;
   endfunction
   function automatic logic busy_of(input int s);
      return (s == 0) ? busy_a : (s == 1) ? busy_b : busy_c;
   endfunction
   function automatic logic done_of(input int s);
      return (s == 0) ? done_a : (s == 1) ? done_b : done_c;
   endfunction
   function automatic logic ready_of(input int s);
      return (s == 0) ? rdy_a : (s == 1) ? rdy_b : rdy_c;
   endfunction

   task automatic drive(input int s, input logic valid, input logic [15:0] data);
      case (s)
         0: begin va = valid; da = data[7:0]; end
         1: begin vb = valid; db = data[7:0]; end
         default: begin vc = valid; dc = data[4:0]; end
      endcase
   endtask

   // Offer a word at a negedge, then check every clock of the resulting frame.
   task automatic run_frame(input int s, input logic [15:0] data, input logic par_bit,
                            input bit hold, input logic [15:0] next_data);
      int          nb;
      int          pos;
      logic [31:0] fr;
      nb = frame_bits(dw_c[s], pm_c[s], sb_c[s]);
      fr = '0;
      for (int i = 0; i < dw_c[s]; i++) fr[1+i] = data[i];
      pos = 1 + dw_c[s];
      if (pm_c[s] != PAR_NONE) begin
         fr[pos] = par_bit;
         pos++;
      end
      for (int i = 0; i < sb_c[s]; i++) fr[pos+i] = 1'b1;
      drive(s, 1'b1, data);
      check($sformatf("ready_before_u%0d", s), ready_of(s), 1);
      @(posedge clk);
      @(negedge clk);
      if (hold) drive(s, 1'b1, next_data);
      else      drive(s, 1'b0, ~data);
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < cpb_c[s]; k++) begin
            check($sformatf("tx_u%0d_bit%0d_clk%0d", s, b, k), tx_of(s), fr[b]);
            check($sformatf("busy_u%0d_bit%0d", s, b), busy_of(s), 1);
            check($sformatf("done_u%0d_bit%0d_clk%0d", s, b, k), done_of(s),
                  (b == nb - 1) && (k == cpb_c[s] - 1));
            @(negedge clk);
         end
      end
      check($sformatf("tx_after_u%0d", s), tx_of(s), 1);
      check($sformatf("busy_after_u%0d", s), busy_of(s), 0);
      check($sformatf("ready_after_u%0d", s), ready_of(s), 1);
   endtask

   // Protocol monitor: line idles high, ready mirrors !busy, count done pulses.
   always @(negedge clk) begin
      if (rst) begin
         if (!busy_a) check("idle_high_a", tx_a, 1);
         if (!busy_b) check("idle_high_b", tx_b, 1);
         if (!busy_c) check("idle_high_c", tx_c, 1);
         check("ready_vs_busy_a", rdy_a, !busy_a);
         check("ready_vs_busy_b", rdy_b, !busy_b);
         check("ready_vs_busy_c", rdy_c, !busy_c);
         if (done_a) dn_a++;
         if (done_b) dn_b++;
         if (done_c) dn_c++;
      end
   end

   always @(posedge clk) begin
      if (rst) begin
         if (va && rdy_a) acc_a++;
         if (vb && rdy_b) acc_b++;
         if (vc && rdy_c) acc_c++;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "watchdog expired");
   end

   initial begin
      va = 1'b0; vb = 1'b0; vc = 1'b0;
      da = '0;   db = '0;   dc = '0;
      rst = 1'b1;
      #1 rst = 1'b0;
      #1;
      for (int s = 0; s < 3; s++) begin
         check($sformatf("rst_tx_u%0d", s), tx_of(s), 1);
         check($sformatf("rst_busy_u%0d", s), busy_of(s), 0);
         check($sformatf("rst_done_u%0d", s), done_of(s), 0);
         check($sformatf("rst_ready_u%0d", s), ready_of(s), 1);
      end
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // 0xA5, even parity 0, one stop: 11 bits x 4 clocks.
      run_frame(0, 16'h00A5, 1'b0, 1'b0, 16'h0);
      // 0x00, odd parity 1, two stops: 12 bits x 4 clocks.
      run_frame(1, 16'h0000, 1'b1, 1'b0, 16'h0);

      // Back-to-back with tx_valid held: 0x3C then 0xC3 (both even parity 0).
      run_frame(0, 16'h003C, 1'b0, 1'b1, 16'h00C3);
      run_frame(0, 16'h00C3, 1'b0, 1'b0, 16'h0);
      @(negedge clk);

      // Reset in the middle of data bit 3 of a 0x00 frame.
      drive(0, 1'b1, 16'h0000);
      @(posedge clk);
      @(negedge clk);
      drive(0, 1'b0, 16'h00FF);
      repeat (17) @(negedge clk);
      check("tx_mid_data3", tx_a, 0);
      check("busy_mid_data3", busy_a, 1);
      #2 rst = 1'b0;
      #1;
      check("tx_async_reset", tx_a, 1);
      check("busy_async_reset", busy_a, 0);
      check("done_async_reset", done_a, 0);
      check("ready_async_reset", rdy_a, 1);
      repeat (2) @(negedge clk);
      check("done_in_reset", done_a, 0);
      rst = 1'b1;
      @(negedge clk);
      check("done_after_release", done_a, 0);
      run_frame(0, 16'h0055, 1'b0, 1'b0, 16'h0);

      // CLKS_PER_BIT=1, 5 data bits 10011: line 0,1,1,0,0,1,1.
      run_frame(2, 16'h0013, 1'b0, 1'b0, 16'h0);
      @(negedge clk);

      check("accepted_a", acc_a, 5);
      check("done_count_a", dn_a, 4);
      check("accepted_b", acc_b, 1);
      check("done_count_b", dn_b, 1);
      check("accepted_c", acc_c, 1);
      check("done_count_c", dn_c, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
